// File: rtl/stall_ctrl_pkg.sv
// Shared CPU pipeline definitions: mult/div latency defaults, counter widths
// and the encoding of the mult/div busy FSM.
package stall_ctrl_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // A 4-bit down-counter caps the busy length at 15 cycles.
    localparam int CNT_W       = 4;
    localparam int STALL_CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: a two-state FSM plus a down-counter that keeps the
// unit busy for a fixed number of cycles after each accepted start pulse.
module md_busy_timer
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Start pulses that arrive while BUSY are ignored; the running count is never reloaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges decode data hazards with mult/div
// structural hazards into fetch/decode enables, a bubble request and a stall counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   D_stall_data,
    input  logic                   D_md_use,
    input  logic                   E_md_start,
    input  logic                   E_md_is_div,
    output logic                   enablePC,
    output logic                   IF_ID_en,
    output logic                   ID_EX_flush,
    output logic                   md_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    logic stall;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .is_div(E_md_is_div),
        .busy  (md_busy)
    );

    // A start pulse in E already blocks a mult/div user in D, before busy rises.
    assign stall       = D_stall_data | (D_md_use & (md_busy | E_md_start));
    assign enablePC    = ~stall;
    assign IF_ID_en    = ~stall;
    assign ID_EX_flush = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl with default mult/div latencies.
module tb_stall_ctrl;

    logic        clk;
    logic        reset;
    logic        D_stall_data;
    logic        D_md_use;
    logic        E_md_start;
    logic        E_md_is_div;
    logic        enablePC;
    logic        IF_ID_en;
    logic        ID_EX_flush;
    logic        md_busy;
    logic [15:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    stall_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .D_stall_data(D_stall_data),
        .D_md_use    (D_md_use),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .enablePC    (enablePC),
        .IF_ID_en    (IF_ID_en),
        .ID_EX_flush (ID_EX_flush),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pipe(input string tag, input logic stalled);
        check({tag, "_enablePC"}, 16'(enablePC), 16'(!stalled));
        check({tag, "_IF_ID_en"}, 16'(IF_ID_en), 16'(!stalled));
        check({tag, "_flush"}, 16'(ID_EX_flush), 16'(stalled));
    endtask

    initial begin
        reset        = 1'b0;
        D_stall_data = 1'b0;
        D_md_use     = 1'b0;
        E_md_start   = 1'b0;
        E_md_is_div  = 1'b0;

        // Reset state with idle inputs.
        #12;
        check_pipe("rst", 1'b0);
        check("rst_busy", 16'(md_busy), 16'd0);
        check("rst_cnt", stall_cnt, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
        check_pipe("idle", 1'b0);
        check("idle_busy", 16'(md_busy), 16'd0);
        check("idle_cnt", stall_cnt, 16'd0);

        // Mult start with a mult/div user in D: stalls in the start cycle too.
        E_md_start = 1'b1;
        E_md_is_div = 1'b0;
        D_md_use = 1'b1;
        #1;
        check_pipe("mult_start", 1'b1);
        check("mult_start_busy", 16'(md_busy), 16'd0);
        tick();
        E_md_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mult_busy", 16'(md_busy), 16'd1);
            check("mult_stall_en", 16'(enablePC), 16'd0);
            tick();
        end
        check("mult_done_busy", 16'(md_busy), 16'd0);
        check_pipe("mult_done", 1'b0);
        check("mult_cnt", stall_cnt, 16'd6);
        D_md_use = 1'b0;

        // Div start without a user in D: busy 10 cycles, no stall.
        E_md_start = 1'b1;
        E_md_is_div = 1'b1;
        #1;
        check("div_start_en", 16'(enablePC), 16'd1);
        tick();
        E_md_start = 1'b0;
        E_md_is_div = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("div_busy", 16'(md_busy), 16'd1);
            check("div_en", 16'(enablePC), 16'd1);
            tick();
        end
        check("div_done_busy", 16'(md_busy), 16'd0);
        check("div_cnt", stall_cnt, 16'd6);

        // Single-cycle data hazard.
        D_stall_data = 1'b1;
        #1;
        check_pipe("data", 1'b1);
        tick();
        D_stall_data = 1'b0;
        #1;
        check_pipe("data_after", 1'b0);
        check("data_cnt", stall_cnt, 16'd7);

        // A second start while busy must not extend the mult window.
        E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0;
        tick();
        E_md_start = 1'b1;
        E_md_is_div = 1'b1;
        tick();
        E_md_start = 1'b0;
        E_md_is_div = 1'b0;
        tick();
        tick();
        check("reload_last", 16'(md_busy), 16'd1);
        tick();
        check("reload_ignored", 16'(md_busy), 16'd0);

        // Reset in the middle of a divide.
        E_md_start = 1'b1;
        E_md_is_div = 1'b1;
        tick();
        E_md_start = 1'b0;
        E_md_is_div = 1'b0;
        repeat (3) tick();
        check("abort_pre", 16'(md_busy), 16'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 16'(md_busy), 16'd0);
        check("abort_cnt", stall_cnt, 16'd0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("abort_rel_busy", 16'(md_busy), 16'd0);
        tick();
        check("abort_rel_busy2", 16'(md_busy), 16'd0);

        // First edge after release already accepts a start.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        E_md_start = 1'b1;
        tick();
        E_md_start = 1'b0;
        check("first_edge_busy", 16'(md_busy), 16'd1);
        repeat (5) tick();
        check("first_edge_done", 16'(md_busy), 16'd0);

        // Saturation of the stall counter.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        D_stall_data = 1'b1;
        repeat (65534) tick();
        check("sat_fffe", stall_cnt, 16'hFFFE);
        tick();
        check("sat_ffff", stall_cnt, 16'hFFFF);
        repeat (4) tick();
        check("sat_hold", stall_cnt, 16'hFFFF);
        D_stall_data = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
